// File: rtl/global_avg_pool.sv
// Streaming global average pool: per-channel sums over HEIGHT x WIDTH_PX positions,
// then one channel per cycle scaled by a Q0.16 reciprocal into a saturated mean vector.

module gap_lane #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 22
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    add,
  input  logic                    ld,
  input  logic signed [WIDTH-1:0] data_in,
  input  logic signed [WIDTH-1:0] scaled,
  output logic signed [ACC_W-1:0] acc,
  output logic signed [WIDTH-1:0] q
);
  // Loading the mean and clearing the sum share a cycle, so the next frame starts at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      q   <= '0;
    end else if (ld) begin
      acc <= '0;
      q   <= scaled;
    end else if (add) begin
      acc <= acc + {{(ACC_W-WIDTH){data_in[WIDTH-1]}}, data_in};
    end
  end
endmodule

module global_avg_pool #(
  parameter int WIDTH     = 16,
  parameter int FRAC      = 8,
  parameter int CHANNELS  = 576,
  parameter int HEIGHT    = 7,
  parameter int WIDTH_PX  = 7,
  parameter int RECIP_Q16 = 1337
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] data_in,
  input  logic                    valid_in,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] data_out [0:CHANNELS-1],
  output logic                    valid_out
);
  localparam int NPOS     = HEIGHT * WIDTH_PX;
  localparam int ACC_W    = WIDTH + $clog2(NPOS);
  localparam int PROD_W   = ACC_W + 17;
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int POS_W    = (NPOS > 1) ? $clog2(NPOS) : 1;
  // Output shares the input Q format, so the reciprocal's 16 fraction bits are the only shift.
  localparam int OUT_FRAC = FRAC;
  localparam int SHIFT    = 16 + FRAC - OUT_FRAC;
  localparam logic [15:0] RECIP = RECIP_Q16[15:0];

  localparam logic signed [PROD_W-1:0] HALF    = {{(PROD_W-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  localparam logic signed [PROD_W-1:0] SAT_MAX = {{(PROD_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] SAT_MIN = {{(PROD_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {ACCUM, DIVIDE, DONE} state_t;

  state_t            state, state_nxt;
  logic [CH_W-1:0]   ch;
  logic [POS_W-1:0]  pos;
  logic              beat, div_step, last_ch, last_pos;

  logic signed [ACC_W-1:0]  acc [0:CHANNELS-1];
  logic signed [ACC_W-1:0]  acc_sel;
  logic signed [PROD_W-1:0] acc_ext, recip_ext, prod, rnd, shifted;
  logic signed [WIDTH-1:0]  scaled;

  assign in_ready  = en && (state == ACCUM);
  assign valid_out = (state == DONE);
  assign beat      = in_ready && valid_in;
  assign div_step  = en && (state == DIVIDE);
  assign last_ch   = (ch == CH_W'(CHANNELS-1));
  assign last_pos  = (pos == POS_W'(NPOS-1));

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (beat && last_ch && last_pos) state_nxt = DIVIDE;
      DIVIDE:  if (div_step && last_ch)         state_nxt = DONE;
      DONE:    if (en)                          state_nxt = ACCUM;
      default:                                  state_nxt = ACCUM;
    endcase
  end

  // ch doubles as the DIVIDE channel index; it is zero on entry to DIVIDE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      ch    <= '0;
      pos   <= '0;
    end else begin
      state <= state_nxt;
      if (beat) begin
        if (last_ch) begin
          ch  <= '0;
          pos <= last_pos ? '0 : pos + 1'b1;
        end else begin
          ch  <= ch + 1'b1;
        end
      end else if (div_step) begin
        ch <= last_ch ? '0 : ch + 1'b1;
      end
    end
  end

  // Single shared scaler; round half-up via +HALF then arithmetic shift, then clamp.
  assign acc_sel   = acc[ch];
  assign acc_ext   = {{(PROD_W-ACC_W){acc_sel[ACC_W-1]}}, acc_sel};
  assign recip_ext = {{(PROD_W-16){1'b0}}, RECIP};
  assign prod      = acc_ext * recip_ext;
  assign rnd       = prod + HALF;
  assign shifted   = rnd >>> SHIFT;

  always_comb begin
    scaled = shifted[WIDTH-1:0];
    if (shifted > SAT_MAX)      scaled = SAT_MAX[WIDTH-1:0];
    else if (shifted < SAT_MIN) scaled = SAT_MIN[WIDTH-1:0];
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    gap_lane #(.WIDTH(WIDTH), .ACC_W(ACC_W)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .add     (beat && (ch == CH_W'(g))),
      .ld      (div_step && (ch == CH_W'(g))),
      .data_in (data_in),
      .scaled  (scaled),
      .acc     (acc[g]),
      .q       (data_out[g])
    );
  end
endmodule

// File: tb/tb_global_avg_pool.sv
// Directed + random bench for global_avg_pool: a 4-channel instance for frame/stall/reset
// behaviour and a default-sized instance for a bit-exact random frame.
module tb_global_avg_pool;
  localparam int C  = 4;
  localparam int NP = 49;
  localparam int CB = 576;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, vin, vin_b, rdy, rdy_b, vout, vout_b;
  logic signed [15:0] din, din_b;
  logic signed [15:0] dout   [0:C-1];
  logic signed [15:0] dout_b [0:CB-1];

  int total = 0;
  int bad   = 0;
  int lat, vcnt, lowc;
  logic signed [15:0] got [0:C-1];
  logic signed [15:0] fr  [0:NP*C-1];
  longint sum_b [0:CB-1];

  global_avg_pool #(.WIDTH(16), .FRAC(8), .CHANNELS(C), .HEIGHT(7), .WIDTH_PX(7), .RECIP_Q16(1337)) u_small (
    .clk(clk), .rst(rst), .en(en), .data_in(din), .valid_in(vin),
    .in_ready(rdy), .data_out(dout), .valid_out(vout));

  global_avg_pool u_big (
    .clk(clk), .rst(rst), .en(en), .data_in(din_b), .valid_in(vin_b),
    .in_ready(rdy_b), .data_out(dout_b), .valid_out(vout_b));

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Mean of a 49-sample sum: floor((s*1337 + 2^15) / 2^16), clamped to 16-bit signed.
  function automatic logic signed [63:0] mean_ref(input longint s);
    longint p, q;
    p = s * 1337 + 32768;
    q = p / 65536;
    if ((p % 65536) != 0 && p < 0) q = q - 1;
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return q;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input bit gaps, input bit stall, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        vin = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
      if (stall && i == 100) begin
        vin = 1'b0;
        en  = 1'b0;
        tick();
        chk("en_low_rdy", rdy, 0);
        tick();
        tick();
        en = 1'b1;
      end
      din = fr[i];
      vin = 1'b1;
      tick();
    end
  endtask

  // Runs from the edge that took the last beat until in_ready returns.
  task automatic finish_frame(input string tag, input bit hold, input bit stall);
    bit done;
    done = 1'b0;
    lat = -1; vcnt = 0; lowc = 0;
    if (!hold) vin = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      if (!rdy) lowc++;
      if (vout) begin
        if (lat < 0) begin
          lat = k;
          for (int c = 0; c < C; c++) got[c] = dout[c];
        end
        vcnt++;
      end
      if (rdy) begin
        vin  = 1'b0;
        done = 1'b1;
      end else begin
        en = 1'b1;
        if (stall && k >= 1 && k <= 3) en = 1'b0;
        if (stall && lat >= 0 && k >= lat && k <= lat + 2) en = 1'b0;
        tick();
      end
    end
    en = 1'b1;
    chk({tag, "_returns"}, done, 1);
  endtask

  task automatic check_means(input string tag);
    longint s [0:C-1];
    for (int c = 0; c < C; c++) s[c] = 0;
    for (int i = 0; i < NP*C; i++) s[i % C] += fr[i];
    for (int c = 0; c < C; c++) chk($sformatf("%s_ch%0d", tag, c), got[c], mean_ref(s[c]));
  endtask

  initial begin
    bit seen;
    rst = 1'b1; en = 1'b1; vin = 1'b0; din = '0; vin_b = 1'b0; din_b = '0;
    tick(); tick();
    chk("rst_vout", vout, 0);
    chk("rst_rdy", rdy, 1);
    chk("rst_dout0", dout[0], 0);
    chk("rst_dout3", dout[3], 0);
    chk("rst_vout_big", vout_b, 0);
    rst = 1'b0;
    tick();

    // 1: all 1.0
    for (int i = 0; i < NP*C; i++) fr[i] = 16'sd256;
    feed(0, 0, NP*C);
    finish_frame("t1", 0, 0);
    chk("t1_latency", lat, 4);
    chk("t1_vout_cycles", vcnt, 1);
    chk("t1_rdy_low", lowc, 5);
    check_means("t1");

    // 2: per-channel negative/zero/positive constants
    for (int i = 0; i < NP*C; i++) fr[i] = 16'(((i % C) - 2) * 256);
    feed(0, 0, NP*C);
    finish_frame("t2", 0, 0);
    check_means("t2");

    // 3: full-scale with valid_in held through DIVIDE, then zeros
    for (int i = 0; i < NP*C; i++) fr[i] = 16'sd32767;
    feed(0, 0, NP*C);
    finish_frame("t3", 1, 0);
    check_means("t3_max");
    for (int i = 0; i < NP*C; i++) fr[i] = 16'sd0;
    feed(0, 0, NP*C);
    finish_frame("t3z", 0, 0);
    check_means("t3_zero");

    // 4: en stalls in ACCUM, DIVIDE and DONE; then random valid gaps
    for (int i = 0; i < NP*C; i++) fr[i] = 16'sd256;
    feed(0, 1, NP*C);
    finish_frame("t4s", 0, 1);
    chk("t4_stall_latency", lat, 7);
    chk("t4_done_hold", vcnt, 4);
    check_means("t4_stall");
    feed(1, 0, NP*C);
    finish_frame("t4g", 0, 0);
    chk("t4_gap_latency", lat, 4);
    check_means("t4_gaps");

    // 5: reset mid-frame discards the partial sums
    for (int i = 0; i < NP*C; i++) fr[i] = 16'($urandom);
    feed(0, 0, 100);
    vin = 1'b0;
    rst = 1'b1;
    tick();
    chk("t5_rst_vout", vout, 0);
    for (int c = 0; c < C; c++) chk($sformatf("t5_rst_dout%0d", c), dout[c], 0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < NP*C; i++) fr[i] = 16'sd128;
    feed(0, 0, NP*C);
    finish_frame("t5", 0, 0);
    check_means("t5");

    // 6: default-sized instance, one random frame
    for (int c = 0; c < CB; c++) sum_b[c] = 0;
    for (int i = 0; i < NP*CB; i++) begin
      din_b = 16'($urandom);
      sum_b[i % CB] += din_b;
      vin_b = 1'b1;
      tick();
    end
    vin_b = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 800 && !seen; k++) begin
      if (vout_b) seen = 1'b1;
      else tick();
    end
    chk("t6_vout_seen", seen, 1);
    if (seen)
      for (int c = 0; c < CB; c++) chk($sformatf("t6_ch%0d", c), dout_b[c], mean_ref(sum_b[c]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
